// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one word read at a time to
// instruction memory and queues {pc, instr} pairs toward decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_GNT,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_RVALID,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR_OUT,
  output logic [31:0] PC_OUT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  state_t              state_q,    state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic [31:0]         req_pc_q,   req_pc_d;
  logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]    count_q,    count_d;
  fetch_entry_t        fifo_q [FIFO_DEPTH];
  fetch_entry_t        fifo_d [FIFO_DEPTH];

  logic issue, push, pop, not_full, head_vld;
  logic unused_redir_lsb;

  assign unused_redir_lsb = ^REDIRECT_PC[1:0];

  assign not_full = (count_q < CNT_W'(FIFO_DEPTH));
  assign head_vld = (count_q != '0);

  // RST_N gating keeps the request quiet while reset is held; everything
  // else on the request side comes from registers.
  assign MEM_REQ  = RST_N & (state_q == S_IDLE) & not_full;
  assign MEM_ADDR = fetch_pc_q;

  assign INSTR_VALID = head_vld;
  assign INSTR_OUT   = head_vld ? fifo_q[rd_ptr_q].instr : 32'h0;
  assign PC_OUT      = head_vld ? fifo_q[rd_ptr_q].pc    : 32'h0;

  assign issue = MEM_REQ & MEM_GNT;
  assign push  = (state_q == S_WAIT) & MEM_RVALID & ~REDIRECT;
  assign pop   = head_vld & INSTR_READY & ~REDIRECT;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          req_pc_d = fetch_pc_q;
          state_d  = REDIRECT ? S_DROP : S_WAIT;
          if (!REDIRECT) fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (MEM_RVALID)    state_d = S_IDLE;
        else if (REDIRECT) state_d = S_DROP;
      end
      S_DROP: begin
        if (MEM_RVALID) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (REDIRECT) fetch_pc_d = {REDIRECT_PC[31:2], 2'b00};
  end

  // A redirect empties the queue outright; the same-cycle push/pop are lost.
  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (REDIRECT) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = '{pc: req_pc_q, instr: MEM_RDATA};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge CLK) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, stall/wrap sequences and a
// randomized run against a queue-based reference model.
module tb_instr_fetch;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MEM_REQ, MEM_GNT = 1'b0, MEM_RVALID = 1'b0;
  logic [31:0] MEM_ADDR, MEM_RDATA = 32'h0;
  logic        REDIRECT = 1'b0, INSTR_READY = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        INSTR_VALID;
  logic [31:0] INSTR_OUT, PC_OUT;

  logic        w_req, w_v;
  logic        w_rv = 1'b0;
  logic [31:0] w_addr, w_instr, w_pc;

  always #5 CLK = ~CLK;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_GNT(MEM_GNT), .MEM_RDATA(MEM_RDATA), .MEM_RVALID(MEM_RVALID),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .INSTR_OUT(INSTR_OUT), .PC_OUT(PC_OUT));

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .MEM_REQ(w_req), .MEM_ADDR(w_addr),
    .MEM_GNT(1'b1), .MEM_RDATA(32'h0), .MEM_RVALID(w_rv),
    .REDIRECT(1'b0), .REDIRECT_PC(32'h0), .INSTR_VALID(w_v),
    .INSTR_READY(1'b1), .INSTR_OUT(w_instr), .PC_OUT(w_pc));

  // Wrap instance: always granted, answers one cycle later; record first 3 addresses.
  int          w_n = 0;
  logic [31:0] w_seen [3];
  always @(posedge CLK) w_rv <= (RST_N === 1'b1) && (w_req === 1'b1);
  always @(negedge CLK)
    if (RST_N === 1'b1 && w_req === 1'b1 && w_n < 3) begin
      w_seen[w_n] <= w_addr;
      w_n         <= w_n + 1;
    end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        m_q [$];
  logic [31:0] m_fetch = 32'h0, m_pc = 32'h0;
  bit          m_out = 0, m_stale = 0, cur_rst = 0, chk_en = 0;
  int          nvec = 0, nerr = 0;

  bit          s_pend = 0;
  int          s_cnt = 0;
  logic [31:0] s_pc = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge CLK);
    if (chk_en) begin
      bit er;
      bit ev;
      er = cur_rst && !m_out && (m_q.size() < DEPTH);
      ev = (m_q.size() > 0);
      chk("mem_req", {31'b0, MEM_REQ}, {31'b0, er});
      chk("mem_addr", MEM_ADDR, m_fetch);
      chk("instr_valid", {31'b0, INSTR_VALID}, {31'b0, ev});
      chk("pc_out", PC_OUT, ev ? m_q[0].pc : 32'h0);
      chk("instr_out", INSTR_OUT, ev ? m_q[0].data : 32'h0);
    end
  endtask

  task automatic drive(input bit rst, input bit gnt, input bit rv, input logic [31:0] rdata,
                       input bit redir, input logic [31:0] rpc, input bit rdy);
    RST_N = rst; MEM_GNT = gnt; MEM_RVALID = rv; MEM_RDATA = rdata;
    REDIRECT = redir; REDIRECT_PC = rpc; INSTR_READY = rdy;
    cur_rst = rst;
    if (!rst) begin
      m_fetch = 32'h0; m_out = 0; m_stale = 0; m_q.delete();
    end else begin
      bit req, resp;
      req  = !m_out && (m_q.size() < DEPTH);
      resp = m_out && rv;
      if (redir) m_q.delete();
      else begin
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (resp && !m_stale) m_q.push_back('{m_pc, rdata});
      end
      if (resp) m_out = 0;
      if (req && gnt) begin
        m_out = 1; m_pc = m_fetch; m_stale = redir;
        if (!redir) m_fetch = m_fetch + 32'd4;
      end
      if (redir) begin
        m_fetch = rpc & ~32'h3;
        m_stale = 1;
      end
    end
    @(posedge CLK);
  endtask

  // One cycle with a behavioural memory slave answering after lat cycles.
  task automatic sl(input bit rst, input bit gnt, input int lat, input bit rdy,
                    input bit redir, input logic [31:0] rpc, input bit stray, output bit granted);
    bit          rv;
    logic [31:0] rd, pc_now;
    rv = s_pend && (s_cnt == 0);
    rd = rv ? memf(s_pc) : $urandom;
    if (!s_pend && stray) rv = 1;
    granted = rst && !m_out && (m_q.size() < DEPTH) && gnt;
    pc_now  = m_fetch;
    drive(rst, gnt, rv, rd, redir, rpc, rdy);
    if (!rst) s_pend = 0;
    else begin
      if (s_pend && s_cnt == 0) s_pend = 0;
      else if (s_pend) s_cnt--;
      if (granted) begin s_pend = 1; s_pc = pc_now; s_cnt = lat - 1; end
    end
  endtask

  typedef struct {
    bit e_req; logic [31:0] e_addr; bit e_v; logic [31:0] e_pc; logic [31:0] e_instr;
    bit rst; bit gnt; bit rv; logic [31:0] rdata; bit redir; logic [31:0] rpc; bit rdy;
  } vec_t;

  localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0004, DX = 32'hDEAD_0104;
  localparam logic [31:0] DY = 32'hDEAD_0200, D2 = 32'hDEAD_0300, D3 = 32'h3333_0400;

  initial begin
    vec_t tab [22];
    bit   g;
    int   ng;
    tab[0]  = '{0, 32'h0,   0, 32'h0,   32'h0, 0,0,0, 32'h0,    0, 32'h0,   0};
    tab[1]  = '{0, 32'h0,   0, 32'h0,   32'h0, 1,1,0, 32'h0,    0, 32'h0,   0};
    tab[2]  = '{0, 32'h4,   0, 32'h0,   32'h0, 1,1,1, D0,       0, 32'h0,   0};
    tab[3]  = '{1, 32'h4,   1, 32'h0,   D0,    1,1,0, 32'h0,    0, 32'h0,   0};
    tab[4]  = '{0, 32'h8,   1, 32'h0,   D0,    1,0,1, D1,       0, 32'h0,   0};
    tab[5]  = '{0, 32'h8,   1, 32'h0,   D0,    1,1,0, 32'h0,    0, 32'h0,   0};
    tab[6]  = '{0, 32'h8,   1, 32'h0,   D0,    1,0,0, 32'h0,    0, 32'h0,   1};
    tab[7]  = '{1, 32'h8,   1, 32'h4,   D1,    1,0,0, 32'h0,    1, 32'h103, 0};
    tab[8]  = '{1, 32'h100, 0, 32'h0,   32'h0, 1,1,0, 32'h0,    0, 32'h0,   1};
    tab[9]  = '{0, 32'h104, 0, 32'h0,   32'h0, 1,0,0, 32'h0,    1, 32'h203, 1};
    tab[10] = '{0, 32'h200, 0, 32'h0,   32'h0, 1,0,1, DX,       0, 32'h0,   1};
    tab[11] = '{1, 32'h200, 0, 32'h0,   32'h0, 1,1,0, 32'h0,    1, 32'h300, 1};
    tab[12] = '{0, 32'h300, 0, 32'h0,   32'h0, 1,0,1, DY,       0, 32'h0,   1};
    tab[13] = '{1, 32'h300, 0, 32'h0,   32'h0, 1,1,0, 32'h0,    0, 32'h0,   1};
    tab[14] = '{0, 32'h304, 0, 32'h0,   32'h0, 1,0,1, D2,       1, 32'h400, 1};
    tab[15] = '{1, 32'h400, 0, 32'h0,   32'h0, 1,1,0, 32'h0,    0, 32'h0,   0};
    tab[16] = '{0, 32'h404, 0, 32'h0,   32'h0, 1,0,1, D3,       0, 32'h0,   0};
    tab[17] = '{1, 32'h404, 1, 32'h400, D3,    1,1,0, 32'h0,    0, 32'h0,   0};
    tab[18] = '{0, 32'h408, 1, 32'h400, D3,    0,0,0, 32'h0,    0, 32'h0,   0};
    tab[19] = '{0, 32'h0,   0, 32'h0,   32'h0, 1,0,1, 32'h5555, 0, 32'h0,   0};
    tab[20] = '{1, 32'h0,   0, 32'h0,   32'h0, 1,0,0, 32'h0,    0, 32'h0,   0};
    tab[21] = '{1, 32'h0,   0, 32'h0,   32'h0, 1,0,0, 32'h0,    0, 32'h0,   0};

    sample();
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
    chk_en = 1;

    for (int i = 0; i < 22; i++) begin
      sample();
      chk($sformatf("row%0d_req", i),   {31'b0, MEM_REQ},     {31'b0, tab[i].e_req});
      chk($sformatf("row%0d_addr", i),  MEM_ADDR,             tab[i].e_addr);
      chk($sformatf("row%0d_valid", i), {31'b0, INSTR_VALID}, {31'b0, tab[i].e_v});
      chk($sformatf("row%0d_pc", i),    PC_OUT,               tab[i].e_pc);
      chk($sformatf("row%0d_instr", i), INSTR_OUT,            tab[i].e_instr);
      drive(tab[i].rst, tab[i].gnt, tab[i].rv, tab[i].rdata, tab[i].redir, tab[i].rpc, tab[i].rdy);
    end

    // Decode stalled: only DEPTH grants, then drain in order.
    for (int i = 0; i < 2; i++) begin sample(); drive(0, 0, 0, 32'h0, 0, 32'h0, 0); end
    ng = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      sl(1, 1, 1, 0, 0, 32'h0, 0, g);
      ng += int'(g);
    end
    chk("stall_grants", ng, 2);
    sample();
    chk("stall_head_pc", PC_OUT, 32'h0);
    sl(1, 1, 1, 1, 0, 32'h0, 0, g);
    sample();
    chk("stall_next_pc", PC_OUT, 32'h4);
    for (int i = 0; i < 12; i++) begin
      sl(1, 1, 1, 1, 0, 32'h0, 0, g);
      sample();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit          rst, redir;
      logic [31:0] rpc;
      rst   = ($urandom % 500) != 0;
      redir = ($urandom % 20) == 0;
      rpc   = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      sl(rst, ($urandom % 4) != 0, int'($urandom_range(1, 4)), ($urandom % 3) != 0,
         redir, rpc, ($urandom % 16) == 0, g);
      sample();
    end

    chk("wrap_count", w_n, 3);
    chk("wrap_addr0", w_seen[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", w_seen[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", w_seen[2], 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
